// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with registered one-hot grant and bounded hold time.
// Optional RR_HOLD_ARBITER_LOCK_EN adds a lock input that suppresses preemption.
module rr_hold_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
`ifdef RR_HOLD_ARBITER_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout
);

  localparam int             CNT_W      = $clog2(MAX_HOLD + 2);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [ID_W:0]  NREQ       = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam bit             PREEMPT_EN = (MAX_HOLD != 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_n;
  logic [ID_W-1:0]    ptr, ptr_n;
  logic [CNT_W-1:0]   hold_cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [ID_W-1:0]    id_n;
  logic               to_n;

  logic [ID_W-1:0]    win_id;
  logic [ID_W:0]      sum;
  logic [ID_W-1:0]    idx;
  logic               own_req, others, lock_ok, preempt;
  logic [ID_W-1:0]    nxt_ptr;

`ifdef RR_HOLD_ARBITER_LOCK_EN
  assign lock_ok = ~lock;
`else
  assign lock_ok = 1'b1;
`endif

  // Scan downward from the farthest offset so the nearest set bit after ptr wins.
  always_comb begin
    win_id = '0;
    sum    = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= NREQ) sum = sum - NREQ;
      idx = sum[ID_W-1:0];
      if (req[idx]) win_id = idx;
    end
  end

  assign own_req = req[gnt_id];
  assign others  = |(req & ~gnt);
  assign preempt = PREEMPT_EN && lock_ok && (hold_cnt == HOLD_MAX) && others;
  assign nxt_ptr = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    id_n    = gnt_id;
    ptr_n   = ptr;
    cnt_n   = hold_cnt;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n        = GRANT;
          gnt_n          = '0;
          gnt_n[win_id]  = 1'b1;
          id_n           = win_id;
          cnt_n          = CNT_W'(1);
        end
      end
      GRANT: begin
        // Release wins over preemption, so a dropping owner never sees timeout.
        if (!own_req || preempt) begin
          state_n = IDLE;
          gnt_n   = '0;
          ptr_n   = nxt_ptr;
          to_n    = own_req;
        end else if (hold_cnt < HOLD_MAX) begin
          cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= id_n;
      ptr      <= ptr_n;
      hold_cnt <= cnt_n;
      timeout  <= to_n;
    end
  end

  assign busy = (state == GRANT);

endmodule
